// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: access sizes,
// controller states and byte-lane indices.
package dm_pkg;

    typedef enum logic [1:0] {
        OP_W   = 2'b00,
        OP_H   = 2'b01,
        OP_B   = 2'b10,
        OP_RSV = 2'b11
    } dm_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_WR   = 3'd4,
        ST_RSP  = 3'd5
    } dm_state_e;

    // Byte lane selected by addr[1:0] (little-endian).
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    // Reserved size, odd half address or unaligned word all abort the access.
    function automatic logic access_error(input dm_op_e op, input logic [1:0] addr_lo);
        logic err;
        case (op)
            OP_W:    err = (addr_lo != 2'b00);
            OP_H:    err = addr_lo[0];
            OP_B:    err = 1'b0;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte/half lane logic: merges store data into a RAM word and extracts an
// extended load value from it. Purely combinational.
module dm_lane_unit
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  dm_op_e      op,
    input  logic        sext,
    input  logic [15:0] st_data,
    input  logic [31:0] ram_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        merged_word = ram_word;
        load_word   = ram_word;
        half_sel    = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];

        case (addr_lo)
            LANE_B0: byte_sel = ram_word[7:0];
            LANE_B1: byte_sel = ram_word[15:8];
            LANE_B2: byte_sel = ram_word[23:16];
            default: byte_sel = ram_word[31:24];
        endcase

        case (op)
            OP_B: begin
                load_word = {{24{sext & byte_sel[7]}}, byte_sel};
                case (addr_lo)
                    LANE_B0: merged_word[7:0]   = st_data[7:0];
                    LANE_B1: merged_word[15:8]  = st_data[7:0];
                    LANE_B2: merged_word[23:16] = st_data[7:0];
                    default: merged_word[31:24] = st_data[7:0];
                endcase
            end
            OP_H: begin
                load_word = {{16{sext & half_sel[15]}}, half_sel};
                if (addr_lo[1]) merged_word[31:16] = st_data;
                else            merged_word[15:0]  = st_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: sequences word/sub-word loads and
// stores onto a single-port synchronous word RAM and reports misalignment.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_op,
    input  logic          req_sext,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wd,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [31:0]   rsp_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    dm_state_e     state_q, state_d;
    dm_op_e        req_op_e;
    logic          accept;
    logic          req_err;

    logic          we_q;
    dm_op_e        op_q;
    logic          sext_q;
    logic [AW+1:0] addr_q;
    logic [15:0]   st_q;
    logic [31:0]   wr_word_q;
    logic [31:0]   rdata_q;

    logic [31:0]   merged_word;
    logic [31:0]   load_word;

    // Byte-address bits above the RAM window wrap and are deliberately dropped.
    logic          unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign req_op_e = dm_op_e'(req_op);
    assign req_err  = access_error(req_op_e, req_addr[1:0]);
    assign accept   = req_valid && (state_q == ST_IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // All outputs decode from state/latched request only, so a reset forces
    // ram_en/ram_we low asynchronously and no partial write can land.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                     state_d = ST_ERR;
                    else if (req_we && req_op_e == OP_W) state_d = ST_WR;
                    else                             state_d = ST_RD;
                end
            end
            ST_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD: begin
                ram_en  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = we_q ? ST_WR : ST_RSP;
            end
            ST_WR: begin
                ram_en  = 1'b1;
                ram_we  = 1'b1;
                state_d = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q      <= 1'b0;
            op_q      <= OP_W;
            sext_q    <= 1'b0;
            addr_q    <= '0;
            st_q      <= '0;
            wr_word_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                we_q   <= req_we;
                op_q   <= req_op_e;
                sext_q <= req_sext;
                addr_q <= req_addr[AW+1:0];
                st_q   <= req_wd[15:0];
                if (req_we && req_op_e == OP_W) wr_word_q <= req_wd;
            end
            // ram_rdata is valid only in WAIT; capture the merge or load result here.
            if (state_q == ST_WAIT) begin
                if (we_q) wr_word_q <= merged_word;
                else      rdata_q   <= load_word;
            end
        end
    end

    dm_lane_unit u_lane (
        .addr_lo     (addr_q[1:0]),
        .op          (op_q),
        .sext        (sext_q),
        .st_data     (st_q),
        .ram_word    (ram_rdata),
        .merged_word (merged_word),
        .load_word   (load_word)
    );

    assign ram_addr  = addr_q[AW+1:2];
    assign ram_wdata = wr_word_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl with a behavioural
// synchronous word RAM attached to its memory port.
module tb_dm_access_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_op = 2'b00;
    logic          req_sext = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wd = '0;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   rsp_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:(1<<AW)-1];
    int          n_rd = 0;
    int          n_wr = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                n_wr          <= n_wr + 1;
                last_wr_addr  <= 32'(ram_addr);
                last_wr_data  <= ram_wdata;
            end else begin
                ram_rdata     <= mem[ram_addr];
                n_rd          <= n_rd + 1;
                last_rd_addr  <= 32'(ram_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for its response pulse; returns with
    // the simulation parked on the negedge where rsp_valid was seen.
    task automatic issue(input logic we, input logic [1:0] op, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wd, output int lat);
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_sext  = sext;
        req_addr  = addr;
        req_wd    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wd    = 32'h5A5A_5A5A;
        lat = 0;
        while (lat < 16) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] op,
                          input logic sext, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_rd, input int exp_wr);
        int lat;
        int rd0, wr0;
        rd0 = n_rd;
        wr0 = n_wr;
        issue(we, op, sext, addr, wd, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_nrd"}, 32'(n_rd - rd0), 32'(exp_rd));
        check({tag, "_nwr"}, 32'(n_wr - wr0), 32'(exp_wr));
    endtask

    initial begin
        int wr0;
        mem[10'h041] = 32'h8899_AABB;
        mem[10'h042] = 32'h0000_0000;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        reset_n = 1'b1;

        // Sub-word loads from 0x104 = 0x8899AABB.
        access("lb_105",  1'b0, 2'b10, 1'b1, 32'h105, 32'h0, 3, 1'b0, 32'hFFFF_FFAA, 1, 0);
        check("lb_rd_addr", last_rd_addr, 32'h41);
        access("lbu_105", 1'b0, 2'b10, 1'b0, 32'h105, 32'h0, 3, 1'b0, 32'h0000_00AA, 1, 0);
        access("lh_106",  1'b0, 2'b01, 1'b1, 32'h106, 32'h0, 3, 1'b0, 32'hFFFF_8899, 1, 0);
        access("lhu_106", 1'b0, 2'b01, 1'b0, 32'h106, 32'h0, 3, 1'b0, 32'h0000_8899, 1, 0);

        // sb to 0x105 with reset pulsed during WAIT: no write, no response.
        wr0 = n_wr;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 2'b10; req_sext = 1'b0;
        req_addr = 32'h105; req_wd = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("sbrst_rd_en", 32'(ram_en), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("sbrst_en_low", 32'(ram_en), 32'd0);
        check("sbrst_we_low", 32'(ram_we), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("sbrst_ready", 32'(req_ready), 32'd1);
        check("sbrst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("sbrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("sbrst_nwr", 32'(n_wr - wr0), 32'd0);
        check("sbrst_mem", mem[10'h041], 32'h8899_AABB);
        check("sbrst_rdata_rst", rsp_rdata, 32'h0);

        // Half store merges into upper lane; rsp_rdata holds through stores.
        access("sh_106", 1'b1, 2'b01, 1'b0, 32'h106, 32'h0000_1234, 4, 1'b0, 32'h0, 1, 1);
        check("sh_wr_addr", last_wr_addr, 32'h41);
        check("sh_wr_data", last_wr_data, 32'h1234_AABB);
        access("lw_104", 1'b0, 2'b00, 1'b0, 32'h104, 32'h0, 3, 1'b0, 32'h1234_AABB, 1, 0);
        // Address bits above the RAM window wrap onto the same word.
        access("lw_wrap", 1'b0, 2'b00, 1'b0, 32'h0000_1104, 32'h0, 3, 1'b0, 32'h1234_AABB, 1, 0);
        check("wrap_rd_addr", last_rd_addr, 32'h41);

        // Word store: no read, one write.
        access("sw_108", 1'b1, 2'b00, 1'b0, 32'h108, 32'hDEAD_BEEF, 2, 1'b0, 32'h1234_AABB, 0, 1);
        check("sw_wr_addr", last_wr_addr, 32'h42);
        check("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);

        // Byte store into lane 0 uses only the low byte of wd.
        access("sb_108", 1'b1, 2'b10, 1'b1, 32'h108, 32'hFFFF_FF77, 4, 1'b0, 32'h1234_AABB, 1, 1);
        check("sb_wr_data", last_wr_data, 32'hDEAD_BE77);
        access("lbu_108", 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 3, 1'b0, 32'h0000_0077, 1, 0);
        access("lb_10b",  1'b0, 2'b10, 1'b1, 32'h10B, 32'h0, 3, 1'b0, 32'hFFFF_FFDE, 1, 0);
        access("lw_sext", 1'b0, 2'b00, 1'b1, 32'h108, 32'h0, 3, 1'b0, 32'hDEAD_BE77, 1, 0);

        // Aborted accesses: error pulse one cycle after accept, RAM untouched.
        access("err_lh_103", 1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 1, 1'b1, 32'hDEAD_BE77, 0, 0);
        access("err_sw_10a", 1'b1, 2'b00, 1'b0, 32'h10A, 32'h1111_2222, 1, 1'b1, 32'hDEAD_BE77, 0, 0);
        access("err_op11",   1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 1, 1'b1, 32'hDEAD_BE77, 0, 0);
        check("err_mem_42", mem[10'h042], 32'hDEAD_BE77);

        @(negedge clk);
        check("end_rsp_valid", 32'(rsp_valid), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
